fifo_burst_reader: RTL and testbench

- Drain engine for the synchronous FIFO read port: pops exactly LEN words on command and presents them as a valid/ready stream with M_LAST on the final word.
- Hides the FIFO's 1-cycle registered read latency with a 3-entry internal buffer, so throughput is 1 word/cycle under continuous M_READY.
- Sits between the FIFO and any downstream consumer (DMA, serializer, packetizer).

---
 rtl/fifo_pkg.sv | 13 +
 rtl/stream_buf3.sv | 53 +++++
 rtl/fifo_burst_reader.sv | 99 +++++++++
 tb/tb_fifo_burst_reader.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared state encoding and buffer sizing for the FIFO burst reader
package fifo_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int BUF_DEPTH = 3;
  localparam int BUF_CW    = 2;

endpackage

// File: rtl/stream_buf3.sv
// rtl/stream_buf3.sv - 3-entry in-order queue whose head drives the output stream
module stream_buf3
  import fifo_pkg::*;
#(
  parameter int DWIDTH = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              clr,
  input  logic              push,
  input  logic              pop,
  input  logic [DWIDTH-1:0] din,
  output logic [DWIDTH-1:0] dout,
  output logic [BUF_CW-1:0] count
);

  logic [DWIDTH-1:0] mem [BUF_DEPTH];
  logic              pop_ok;
  logic              push_ok;
  logic [BUF_CW-1:0] wr_idx;

  // a pop needs a word; a push needs a free slot, or one being freed this cycle
  assign pop_ok  = pop & (count != '0);
  assign push_ok = push & ((count != BUF_CW'(BUF_DEPTH)) | pop_ok);
  assign wr_idx  = count - {{(BUF_CW-1){1'b0}}, pop_ok};
  assign dout    = mem[0];

  // shift-toward-head storage: pop moves every entry down, push lands behind the last live entry
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
    end else if (!clr) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        if (pop_ok && i < BUF_DEPTH - 1) mem[i] <= mem[i+1];
        if (push_ok && BUF_CW'(i) == wr_idx) mem[i] <= din;
      end
    end
  end

  // occupancy; simultaneous push and pop leave it unchanged
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (push_ok && !pop_ok) begin
      count <= count + 1'b1;
    end else if (pop_ok && !push_ok) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/fifo_burst_reader.sv
// rtl/fifo_burst_reader.sv - pops LEN words from a registered-read FIFO and streams them out
module fifo_burst_reader
  import fifo_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int LWIDTH = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic [LWIDTH-1:0] LEN,
  input  logic              ABORT,
  output logic              BUSY,
  output logic              DONE,
  output logic              FIFO_RD_EN,
  input  logic [DWIDTH-1:0] FIFO_DOUT,
  input  logic              FIFO_EMPTY,
  output logic              M_VALID,
  output logic [DWIDTH-1:0] M_DATA,
  output logic              M_LAST,
  input  logic              M_READY
);

  state_t            state;
  state_t            state_nxt;
  logic [LWIDTH-1:0] issue_left;
  logic [LWIDTH-1:0] out_left;
  logic              inflight;
  logic [BUF_CW-1:0] buf_count;
  logic [BUF_CW:0]   occupancy;
  logic              hs;
  logic              run_abort;

  // words already committed to the buffer: stored plus the one returning from the FIFO
  assign occupancy = {1'b0, buf_count} + {{BUF_CW{1'b0}}, inflight};
  assign hs        = M_VALID & M_READY;
  assign run_abort = (state == S_RUN) & ABORT;
  assign M_VALID   = (buf_count != '0);
  assign M_LAST    = M_VALID & (out_left == LWIDTH'(1));

  // pop only when a slot is guaranteed for the returning word; no path from M_READY
  assign FIFO_RD_EN = (state == S_RUN) & ~ABORT & ~FIFO_EMPTY & (issue_left != '0)
                    & (occupancy <= (BUF_CW+1)'(2));

  // state register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // next state and status outputs
  always_comb begin
    state_nxt = state;
    BUSY      = (state != S_IDLE);
    DONE      = (state == S_DONE);
    case (state)
      S_IDLE: if (START) state_nxt = (LEN == '0) ? S_DONE : S_RUN;
      S_RUN: begin
        if (ABORT)                                state_nxt = S_IDLE;
        else if (hs && out_left == LWIDTH'(1))    state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // issue/output counters and the read-latency flag
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      issue_left <= '0;
      out_left   <= '0;
      inflight   <= 1'b0;
    end else if (state == S_IDLE && START) begin
      issue_left <= LEN;
      out_left   <= LEN;
      inflight   <= 1'b0;
    end else if (run_abort) begin
      issue_left <= '0;
      out_left   <= '0;
      inflight   <= 1'b0;
    end else begin
      if (FIFO_RD_EN) issue_left <= issue_left - 1'b1;
      if (hs)         out_left   <= out_left - 1'b1;
      inflight <= FIFO_RD_EN;
    end
  end

  stream_buf3 #(.DWIDTH(DWIDTH)) u_buf (
    .CLK   (CLK),
    .RST   (RST),
    .clr   (run_abort),
    .push  (inflight),
    .pop   (hs),
    .din   (FIFO_DOUT),
    .dout  (M_DATA),
    .count (buf_count)
  );

endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb/tb_fifo_burst_reader.sv - randomized self-checking bench for fifo_burst_reader
module tb_fifo_burst_reader;

  localparam int DW = 32;
  localparam int LW = 16;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          START = 1'b0;
  logic [LW-1:0] LEN = '0;
  logic          ABORT = 1'b0;
  logic          M_READY = 1'b0;
  logic [DW-1:0] FIFO_DOUT = '0;
  logic          FIFO_EMPTY;
  logic          BUSY, DONE, FIFO_RD_EN, M_VALID, M_LAST;
  logic [DW-1:0] M_DATA;

  int checks = 0;
  int errors = 0;

  fifo_burst_reader #(.DWIDTH(DW), .LWIDTH(LW)) dut (
    .CLK(CLK), .RST(RST), .START(START), .LEN(LEN), .ABORT(ABORT), .BUSY(BUSY), .DONE(DONE),
    .FIFO_RD_EN(FIFO_RD_EN), .FIFO_DOUT(FIFO_DOUT), .FIFO_EMPTY(FIFO_EMPTY),
    .M_VALID(M_VALID), .M_DATA(M_DATA), .M_LAST(M_LAST), .M_READY(M_READY)
  );

  always #5 CLK = ~CLK;

  // synchronous FIFO model with a registered read port; pointers ignore RST
  logic [DW-1:0] mem [256];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign FIFO_EMPTY = (wr_ptr == rd_ptr);
  always @(posedge CLK) begin
    if (FIFO_RD_EN && rd_ptr != wr_ptr) begin
      FIFO_DOUT <= mem[rd_ptr % 256];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  // reference: every word written, in order; a burst of N must emit the next N
  logic [DW-1:0] exp_q [$];

  // observations gathered by run_burst
  logic [DW-1:0] got [$];
  logic          lst [$];
  int pops, dones, first_valid, done_cyc, last_hs_cyc, stall_bad, occ_bad, gap_lows, busy_tail, timed_out;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    mem[wr_ptr % 256] = w;
    wr_ptr = wr_ptr + 1;
    exp_q.push_back(w);
  endtask

  // mode 0: always ready, 1: ready every third cycle, 2: random ready
  task automatic run_burst(input int len, input int mode, input int late_at, input int late_n, input int restart_at);
    logic          pv_stall;
    logic [DW-1:0] pdata;
    got.delete(); lst.delete();
    pops = 0; dones = 0; first_valid = -1; done_cyc = -1; last_hs_cyc = -1;
    stall_bad = 0; occ_bad = 0; gap_lows = 0; busy_tail = 0; timed_out = 1;
    pv_stall = 1'b0; pdata = '0;
    START = 1'b1; LEN = LW'(len);
    tick();
    START = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (c == late_at) for (int k = 0; k < late_n; k++) push_word($urandom);
      START = (c == restart_at);
      if (START) LEN = LW'(3);
      case (mode)
        0:       M_READY = 1'b1;
        1:       M_READY = (c % 3 == 0);
        default: M_READY = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (pv_stall && (!M_VALID || M_DATA !== pdata)) stall_bad++;
      if (M_VALID && first_valid < 0) first_valid = c;
      if (!M_VALID && got.size() > 0 && got.size() < len) gap_lows++;
      if (FIFO_RD_EN) begin
        if (pops - got.size() > 2) occ_bad++;
        pops++;
      end
      if (DONE) begin
        dones++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (done_cyc >= 0 && c > done_cyc && BUSY) busy_tail++;
      if (M_VALID && M_READY) begin
        got.push_back(M_DATA);
        lst.push_back(M_LAST);
        last_hs_cyc = c;
      end
      pv_stall = M_VALID && !M_READY;
      pdata    = M_DATA;
      if (done_cyc >= 0 && c >= done_cyc + 3) begin
        timed_out = 0;
        break;
      end
      tick();
    end
    START = 1'b0; M_READY = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b0;
    tick(); tick();
    checks++;
    if ({BUSY, DONE, FIFO_RD_EN, M_VALID, M_LAST} !== 5'b0 || M_DATA !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %b data %0h exp 00000 data 0", {BUSY, DONE, FIFO_RD_EN, M_VALID, M_LAST}, M_DATA);
    end
    RST = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [DW-1:0] e;
    int nl;
    for (int i = 0; i < 8; i++) push_word(DW'(32'h10 + i));
    run_burst(8, 0, -1, 0, -1);
    nl = 0;
    for (int i = 0; i < 8; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (i >= got.size() || got[i] !== e) begin
        errors++;
        $display("FAIL basic_word%0d got %0h exp %0h", i, (i < got.size()) ? got[i] : '1, e);
      end
      if (i < lst.size() && lst[i]) nl++;
    end
    checks++;
    if (nl != 1 || lst.size() != 8 || lst[7] !== 1'b1) begin
      errors++; $display("FAIL basic_last got %0d flags exp 1 on word 7", nl);
    end
    checks++;
    if (first_valid != 2 || last_hs_cyc != 9) begin
      errors++; $display("FAIL basic_timing got first %0d last %0d exp 2 9", first_valid, last_hs_cyc);
    end
    checks++;
    if (timed_out != 0 || dones != 1 || done_cyc != last_hs_cyc + 1 || busy_tail != 0) begin
      errors++;
      $display("FAIL basic_done got to %0d dones %0d cyc %0d busy %0d exp 0 1 %0d 0", timed_out, dones, done_cyc, busy_tail, last_hs_cyc + 1);
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] e;
    int bad;
    for (int i = 0; i < 8; i++) push_word(DW'(32'h10 + i));
    run_burst(8, 1, -1, 0, 3);
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      e = exp_q.pop_front();
      if (i >= got.size() || got[i] !== e) bad++;
    end
    checks++;
    if (bad != 0 || got.size() != 8) begin
      errors++; $display("FAIL bp_order got %0d bad of %0d words exp 0 of 8", bad, got.size());
    end
    checks++;
    if (stall_bad != 0) begin errors++; $display("FAIL bp_stable got %0d changes exp 0", stall_bad); end
    checks++;
    if (occ_bad != 0 || pops != 8) begin
      errors++; $display("FAIL bp_pops got over %0d pops %0d exp 0 8", occ_bad, pops);
    end
    checks++;
    if (timed_out != 0 || dones != 1 || busy_tail != 0) begin
      errors++; $display("FAIL bp_restart got to %0d dones %0d busy %0d exp 0 1 0", timed_out, dones, busy_tail);
    end
  endtask

  task automatic test_empty_mid();
    logic [DW-1:0] e;
    int bad;
    push_word($urandom); push_word($urandom);
    run_burst(5, 0, 10, 3, -1);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      e = exp_q.pop_front();
      if (i >= got.size() || got[i] !== e) bad++;
    end
    checks++;
    if (bad != 0 || got.size() != 5) begin
      errors++; $display("FAIL empty_order got %0d bad of %0d words exp 0 of 5", bad, got.size());
    end
    checks++;
    if (gap_lows == 0) begin errors++; $display("FAIL empty_gap got %0d idle cycles exp >0", gap_lows); end
    checks++;
    if (timed_out != 0 || dones != 1 || done_cyc != last_hs_cyc + 1) begin
      errors++; $display("FAIL empty_done got dones %0d cyc %0d exp 1 %0d", dones, done_cyc, last_hs_cyc + 1);
    end
  endtask

  task automatic test_len_zero();
    logic [DW-1:0] e;
    int bad;
    push_word($urandom); push_word($urandom);
    run_burst(0, 0, -1, 0, -1);
    checks++;
    if (done_cyc != 0 || dones != 1 || busy_tail != 0) begin
      errors++; $display("FAIL len0_done got cyc %0d dones %0d busy %0d exp 0 1 0", done_cyc, dones, busy_tail);
    end
    checks++;
    if (pops != 0 || first_valid != -1 || got.size() != 0) begin
      errors++; $display("FAIL len0_quiet got pops %0d valid_at %0d words %0d exp 0 -1 0", pops, first_valid, got.size());
    end
    run_burst(2, 0, -1, 0, -1);
    bad = 0;
    for (int i = 0; i < 2; i++) begin
      e = exp_q.pop_front();
      if (i >= got.size() || got[i] !== e) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL len0_untouched got %0d bad words exp 0", bad); end
  endtask

  task automatic test_random();
    logic [DW-1:0] e;
    int len, late, bad, nl;
    for (int b = 0; b < 6; b++) begin
      len  = $urandom_range(1, 12);
      late = $urandom_range(0, len);
      for (int i = 0; i < len - late; i++) push_word($urandom);
      run_burst(len, 2, $urandom_range(3, 15), late, -1);
      bad = 0; nl = 0;
      for (int i = 0; i < len; i++) begin
        e = exp_q.pop_front();
        if (i >= got.size() || got[i] !== e) bad++;
        if (i < lst.size() && lst[i] && i != len - 1) nl++;
      end
      checks++;
      if (bad != 0 || got.size() != len) begin
        errors++; $display("FAIL rand%0d_order got %0d bad of %0d words exp 0 of %0d", b, bad, got.size(), len);
      end
      checks++;
      if (nl != 0 || lst.size() != len || lst[len-1] !== 1'b1) begin
        errors++; $display("FAIL rand%0d_last got %0d early flags exp 0 and final flag", b, nl);
      end
      checks++;
      if (stall_bad != 0 || occ_bad != 0) begin
        errors++; $display("FAIL rand%0d_flow got unstable %0d over %0d exp 0 0", b, stall_bad, occ_bad);
      end
      checks++;
      if (timed_out != 0 || dones != 1 || done_cyc != last_hs_cyc + 1) begin
        errors++; $display("FAIL rand%0d_done got to %0d dones %0d cyc %0d exp 0 1 %0d", b, timed_out, dones, done_cyc, last_hs_cyc + 1);
      end
    end
  endtask

  task automatic test_abort();
    logic [DW-1:0] e;
    int hs, guard, bad, d;
    for (int i = 0; i < 8; i++) push_word($urandom);
    got.delete();
    START = 1'b1; LEN = LW'(16); M_READY = 1'b1;
    tick();
    START = 1'b0;
    hs = 0; guard = 0;
    while (hs < 4 && guard < 50) begin
      #1;
      if (M_VALID) begin got.push_back(M_DATA); hs++; end
      guard++;
      tick();
    end
    ABORT = 1'b1;
    tick();
    ABORT = 1'b0;
    #1;
    checks++;
    if ({M_VALID, BUSY, DONE, FIFO_RD_EN} !== 4'b0) begin
      errors++; $display("FAIL abort_state got %b exp 0000", {M_VALID, BUSY, DONE, FIFO_RD_EN});
    end
    d = 0;
    for (int i = 0; i < 4; i++) begin tick(); if (DONE || BUSY) d++; end
    checks++;
    if (d != 0) begin errors++; $display("FAIL abort_nodone got %0d busy/done cycles exp 0", d); end
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      e = exp_q.pop_front();
      if (i >= got.size() || got[i] !== e) bad++;
    end
    checks++;
    if (bad != 0 || hs != 4) begin errors++; $display("FAIL abort_words got %0d bad of %0d exp 0 of 4", bad, hs); end
    // two more words were popped before the abort landed and are lost
    void'(exp_q.pop_front());
    void'(exp_q.pop_front());
    M_READY = 1'b0;
    run_burst(2, 0, -1, 0, -1);
    bad = 0;
    for (int i = 0; i < 2; i++) begin
      e = exp_q.pop_front();
      if (i >= got.size() || got[i] !== e) bad++;
    end
    checks++;
    if (bad != 0 || got.size() != 2) begin
      errors++; $display("FAIL abort_resume got %0d bad of %0d exp 0 of 2", bad, got.size());
    end
  endtask

  task automatic test_reset_mid();
    int guard;
    for (int i = 0; i < 8; i++) push_word($urandom);
    START = 1'b1; LEN = LW'(8); M_READY = 1'b0;
    tick();
    START = 1'b0;
    guard = 0;
    while (!M_VALID && guard < 10) begin tick(); guard++; end
    checks++;
    if (M_VALID !== 1'b1) begin errors++; $display("FAIL rstmid_valid got %b exp 1", M_VALID); end
    RST = 1'b0;
    #1;
    checks++;
    if ({BUSY, DONE, FIFO_RD_EN, M_VALID, M_LAST} !== 5'b0 || M_DATA !== '0) begin
      errors++;
      $display("FAIL rstmid_async got %b data %0h exp 00000 data 0", {BUSY, DONE, FIFO_RD_EN, M_VALID, M_LAST}, M_DATA);
    end
    START = 1'b1; LEN = LW'(4);
    tick(); tick();
    checks++;
    if (BUSY !== 1'b0) begin errors++; $display("FAIL rstmid_start_held got %b exp 0", BUSY); end
    RST = 1'b1; START = 1'b0;
    tick();
    checks++;
    if (BUSY !== 1'b0 || FIFO_RD_EN !== 1'b0) begin
      errors++; $display("FAIL rstmid_release got busy %b rd %b exp 0 0", BUSY, FIFO_RD_EN);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_empty_mid();
    test_len_zero();
    test_random();
    test_abort();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
